mux_demux_scheduler: RTL and testbench

- Round-robin controller sharing one registered mux-to-demux lane among NUM_CH producer/consumer channel pairs.
- Producers offer words on valid/ready. The scheduler grants one producer per cycle and latches its word plus channel ID into the shared lane register.
- It steers the lane to the matching consumer.
- Sits between flattened multi-channel buses and downstream per-channel sinks; exports the select it applies for observability.

---
 rtl/mux_demux_sched_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/mux_demux_scheduler.sv | 91 +++++++++
 tb/tb_mux_demux_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_demux_sched_pkg.sv
// Shared types and helpers for the shared-lane mux/demux scheduler.
// STATS_W sizes the optional per-channel transfer counters.
package mux_demux_sched_pkg;

   typedef enum logic {LANE_EMPTY, LANE_FULL} lane_state_t;

   localparam int unsigned STATS_W = 16;

   function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
// Emits a one-hot grant and its index; both zero when nothing requests.
module rr_arbiter #(
   parameter int unsigned NUM_CH = 2,
   localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_CH-1:0] gnt,
   output logic [SEL_W-1:0]  gnt_idx
);

   logic found;

   // Two passes: channels at/after ptr first, then the wrapped-around remainder.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!found && req[i] && (i >= 32'(ptr))) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = SEL_W'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!found && req[i]) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/mux_demux_scheduler.sv
// Round-robin scheduler sharing one registered lane among NUM_CH producer/consumer pairs.
// Define MUX_DEMUX_SCHEDULER_STATS_EN to add per-channel transfer counters (xfer_count).
module mux_demux_scheduler
   import mux_demux_sched_pkg::*;
#(
   parameter int unsigned WIDTH  = 25,
   parameter int unsigned NUM_CH = 2,
   localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH*WIDTH-1:0]   in_data,
   input  logic [NUM_CH-1:0]         in_valid,
   output logic [NUM_CH-1:0]         in_ready,
   output logic [NUM_CH*WIDTH-1:0]   out_data,
   output logic [NUM_CH-1:0]         out_valid,
   input  logic [NUM_CH-1:0]         out_ready,
   output logic [SEL_W-1:0]          sel,
`ifdef MUX_DEMUX_SCHEDULER_STATS_EN
   output logic [NUM_CH*STATS_W-1:0] xfer_count,
`endif
   output logic                      busy
);

   lane_state_t       state;
   logic [WIDTH-1:0]  lane_data;
   logic [WIDTH-1:0]  gnt_word;
   logic [SEL_W-1:0]  ptr;
   logic [NUM_CH-1:0] gnt;
   logic [SEL_W-1:0]  gnt_idx;
   logic              sel_ready;
   logic              can_accept;
   logic              accept;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req     (in_valid),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign sel_ready  = out_ready[sel];
   assign can_accept = (state == LANE_EMPTY) || sel_ready;
   assign in_ready   = (rst || !can_accept) ? '0 : gnt;
   assign accept     = |(in_valid & in_ready);

   always_comb begin
      gnt_word = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (gnt[i]) gnt_word = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LANE_EMPTY;
         lane_data <= '0;
         sel       <= '0;
         ptr       <= '0;
      end else if (accept) begin
         state     <= LANE_FULL;
         lane_data <= gnt_word;
         sel       <= gnt_idx;
         ptr       <= SEL_W'(next_idx(32'(gnt_idx), NUM_CH));
      end else if (sel_ready) begin
         state     <= LANE_EMPTY;
      end
   end

   always_comb begin
      out_valid = '0;
      if (state == LANE_FULL) out_valid[sel] = 1'b1;
   end

   assign out_data = {NUM_CH{lane_data}};
   assign busy     = (state == LANE_FULL);

`ifdef MUX_DEMUX_SCHEDULER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_count <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (out_valid[i] && out_ready[i])
               xfer_count[i*STATS_W +: STATS_W] <= xfer_count[i*STATS_W +: STATS_W] + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mux_demux_scheduler.sv
// Directed bench for mux_demux_scheduler with a transaction-level reference model.
// Covers the optional counters when MUX_DEMUX_SCHEDULER_STATS_EN is defined.
module tb_mux_demux_scheduler;

   localparam int W = 25;
   localparam int N = 2;

   localparam logic [W-1:0] W1 = 25'b10000_01000_00100_00010_00001;
   localparam logic [W-1:0] W0 = 25'b11111_01111_00111_00011_00001;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [N*W-1:0] out_data;
   logic [N-1:0]   out_valid;
   logic [N-1:0]   out_ready;
   logic           sel;
   logic           busy;
`ifdef MUX_DEMUX_SCHEDULER_STATS_EN
   logic [N*16-1:0] xfer_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit done     = 1'b0;

   mux_demux_scheduler #(.WIDTH(W), .NUM_CH(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sel        (sel),
`ifdef MUX_DEMUX_SCHEDULER_STATS_EN
      .xfer_count (xfer_count),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: lane contents as a transaction, grant by modular scan.
   bit          m_full = 1'b0;
   logic [W-1:0] m_data = '0;
   int          m_sel  = 0;
   int          m_ptr  = 0;
   int          m_cnt [N];

   initial begin
      int g;
      bit can;
      logic [N-1:0] exp_rdy, exp_ov;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      @(posedge clk);
      while (!done) begin
         @(negedge clk);
         can = !m_full || out_ready[m_sel];
         g = -1;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (g < 0 && in_valid[c]) g = c;
         end
         exp_rdy = '0;
         if (!rst && can && g >= 0) exp_rdy[g] = 1'b1;
         exp_ov = '0;
         if (m_full) exp_ov[m_sel] = 1'b1;
         check("model_in_ready", 64'(in_ready), 64'(exp_rdy));
         check("model_out_valid", 64'(out_valid), 64'(exp_ov));
         check("model_busy", 64'(busy), 64'(m_full));
         check("model_sel", 64'(sel), 64'(m_sel));
         if (m_full)
            for (int i = 0; i < N; i++)
               check("model_out_data", 64'(out_data[i*W +: W]), 64'(m_data));
`ifdef MUX_DEMUX_SCHEDULER_STATS_EN
         for (int i = 0; i < N; i++)
            check("model_xfer_count", 64'(xfer_count[i*16 +: 16]), 64'(m_cnt[i]));
`endif
         if (rst) begin
            m_full = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
         end else begin
            if (m_full && out_ready[m_sel]) begin
               m_cnt[m_sel] = (m_cnt[m_sel] + 1) % 65536;
               m_full = 1'b0;
            end
            if (exp_rdy != '0) begin
               m_full = 1'b1;
               m_data = in_data[g*W +: W];
               m_sel  = g;
               m_ptr  = (g + 1) % N;
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 2'b11; out_ready = 2'b00; in_data = {W1, W0};

      // Reset held two cycles with both producers valid
      repeat (2) begin
         @(negedge clk);
         check("rst_in_ready", 64'(in_ready), 64'd0);
         check("rst_out_valid", 64'(out_valid), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
         check("rst_sel", 64'(sel), 64'd0);
      end
      tick(); rst = 1'b0; out_ready = 2'b11;
      @(negedge clk); check("first_grant", 64'(in_ready), 64'b01);
      tick(); in_valid = 2'b00;
      @(negedge clk);
      check("first_out_valid", 64'(out_valid), 64'b01);
      check("first_data", 64'(out_data[W-1:0]), 64'(W0));
      tick();

      // Single word on channel 1
      in_valid = 2'b10;
      @(negedge clk); check("single_in_ready", 64'(in_ready), 64'b10);
      tick(); in_valid = 2'b00;
      @(negedge clk);
      check("single_out_valid", 64'(out_valid), 64'b10);
      check("single_sel", 64'(sel), 64'd1);
      check("single_data", 64'(out_data[2*W-1:W]), 64'(W1));
      tick();

      // Fairness: alternating grants, one transfer per cycle
      in_valid = 2'b11;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k < 10) check("fair_in_ready", 64'(in_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
         if (k >= 1) begin
            check("fair_sel", 64'(sel), 64'((k - 1) % 2));
            check("fair_out_valid", 64'(out_valid), ((k - 1) % 2 == 0) ? 64'b01 : 64'b10);
            if ((k - 1) % 2 == 0) check("fair_data", 64'(out_data[W-1:0]), 64'(W0));
         end
         tick();
         if (k == 9) in_valid = 2'b00;
      end

      // Backpressure on channel 0 with channel 1 pending
      in_valid = 2'b01; out_ready = 2'b00;
      @(negedge clk); check("bp_accept", 64'(in_ready), 64'b01);
      tick(); in_valid = 2'b10;
      repeat (3) begin
         @(negedge clk);
         check("bp_sel", 64'(sel), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'b01);
         check("bp_data", 64'(out_data[W-1:0]), 64'(W0));
         check("bp_in_ready", 64'(in_ready), 64'd0);
         tick();
      end
      out_ready = 2'b01;
      @(negedge clk); check("bp_release", 64'(in_ready), 64'b10);
      tick(); in_valid = 2'b00; out_ready = 2'b00;
      @(negedge clk);
      check("bp_next_sel", 64'(sel), 64'd1);
      check("bp_next_out_valid", 64'(out_valid), 64'b10);

      // Reset while FULL on channel 1
      tick(); rst = 1'b1; in_valid = 2'b01;
      @(negedge clk); check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      tick(); rst = 1'b0; in_valid = 2'b11;
      @(negedge clk);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ptr", 64'(in_ready), 64'b01);
      tick(); in_valid = 2'b00; out_ready = 2'b11;
      @(negedge clk); check("mid_rst_after", 64'(out_valid), 64'b01);
      tick();

`ifdef MUX_DEMUX_SCHEDULER_STATS_EN
      rst = 1'b1; tick(); rst = 1'b0;
      in_valid = 2'b11; repeat (6) tick();
      in_valid = 2'b01; repeat (2) tick();
      in_valid = 2'b00; repeat (2) tick();
      @(negedge clk); check("stats_5_3", 64'(xfer_count), 64'({16'd3, 16'd5}));
      tick();
      in_valid = 2'b01; repeat (65530) tick();
      in_valid = 2'b00; repeat (2) tick();
      @(negedge clk); check("stats_ffff", 64'(xfer_count[15:0]), 64'hFFFF);
      tick();
      in_valid = 2'b01; tick();
      in_valid = 2'b00; repeat (2) tick();
      @(negedge clk);
      check("stats_wrap", 64'(xfer_count[15:0]), 64'd0);
      check("stats_ch1", 64'(xfer_count[31:16]), 64'd3);
`endif

      done = 1'b1;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
